// File: rtl/cheri_regfile_mp.sv
// Multi-ported capability register file with tag reservation/revocation
// channels and a sequential tag-sweep engine. A capability (reg_cap_t) is a
// CapW-bit word whose bit 0 is the valid/tag bit; NULL_REG_CAP is all zeros.
module cheri_regfile_mp #(
  parameter int unsigned NREGS      = 32,
  parameter int unsigned NCAPS      = 32,
  parameter int unsigned NRdPorts   = 3,
  parameter int unsigned NWrPorts   = 2,
  parameter int unsigned NTrvk      = 2,
  parameter bit          WrFwd      = 1'b1,
  parameter bit          TRVKBypass = 1'b1,
  parameter int unsigned CapW       = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NRdPorts-1:0][4:0]           raddr_i,
  output logic [NRdPorts-1:0][31:0]          rdata_o,
  output logic [NRdPorts-1:0][CapW-1:0]      rcap_o,
  input  logic [NWrPorts-1:0][4:0]           waddr_i,
  input  logic [NWrPorts-1:0][31:0]          wdata_i,
  input  logic [NWrPorts-1:0][CapW-1:0]      wcap_i,
  input  logic [NWrPorts-1:0]                we_i,
  input  logic [NTrvk-1:0][4:0]              trvk_addr_i,
  input  logic [NTrvk-1:0]                   trvk_en_i,
  input  logic [NTrvk-1:0]                   trvk_clrtag_i,
  input  logic [4:0]                         trsv_addr_i,
  input  logic                               trsv_en_i,
  output logic [31:0]                        reg_rdy_o,
  input  logic                               sweep_req_i,
  output logic                               sweep_busy_o,
  output logic                               sweep_done_o,
  output logic                               alert_o
);

  typedef enum logic [1:0] {StIdle, StSweep, StDone} sweep_state_e;

  // Storage is sized for the full 5-bit address space; entries outside
  // NREGS/NCAPS are held at zero so they read back as 0 / NULL.
  logic [31:0][31:0]     r_data, w_data_d;
  logic [31:0][CapW-1:0] r_cap, w_cap_d;
  logic [31:0]           r_rdy, w_rdy_d;
  logic                  r_alert;
  sweep_state_e          r_state, w_state_d;
  logic [4:0]            r_idx, w_idx_d;

  logic [31:0]           w_wr_hit;
  logic [31:0][31:0]     w_wr_data;
  logic [31:0][CapW-1:0] w_wr_cap;
  logic                  w_conflict;
  logic [31:0]           w_clr, w_rvk, w_rsv, w_swp;

  // Write decode: later (higher-index) ports override earlier ones.
  always_comb begin
    w_wr_hit   = '0;
    w_wr_data  = '0;
    w_wr_cap   = '0;
    w_conflict = 1'b0;
    for (int unsigned i = 1; i < 32; i++) begin
      for (int unsigned p = 0; p < NWrPorts; p++) begin
        if (we_i[p] && waddr_i[p] == 5'(i) && i < NREGS) begin
          w_wr_hit[i]  = 1'b1;
          w_wr_data[i] = wdata_i[p];
          w_wr_cap[i]  = (i < NCAPS) ? wcap_i[p] : '0;
        end
      end
    end
    for (int unsigned p = 0; p < NWrPorts; p++) begin
      for (int unsigned q = p + 1; q < NWrPorts; q++) begin
        if (we_i[p] && we_i[q] && waddr_i[p] == waddr_i[q]) w_conflict = 1'b1;
      end
    end
  end

  // Revocation, reservation and sweep-index decode.
  always_comb begin
    w_clr = '0;
    w_rvk = '0;
    w_rsv = '0;
    w_swp = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      for (int unsigned c = 0; c < NTrvk; c++) begin
        if (trvk_en_i[c] && trvk_addr_i[c] == 5'(i)) begin
          w_rvk[i] = 1'b1;
          if (trvk_clrtag_i[c]) w_clr[i] = 1'b1;
        end
      end
      w_rsv[i] = trsv_en_i && (trsv_addr_i == 5'(i));
      w_swp[i] = (r_state == StSweep) && (r_idx == 5'(i));
    end
  end

  // Next stored state: cap priority is revocation clear > write > sweep clear.
  always_comb begin
    w_data_d = r_data;
    w_cap_d  = r_cap;
    w_rdy_d  = r_rdy;
    for (int unsigned i = 0; i < 32; i++) begin
      if (w_swp[i]) w_cap_d[i][0] = 1'b0;
      if (w_wr_hit[i]) begin
        w_data_d[i] = w_wr_data[i];
        w_cap_d[i]  = w_wr_cap[i];
      end
      if (w_clr[i]) w_cap_d[i][0] = 1'b0;
      if (i == 0 || i >= NCAPS) w_cap_d[i] = '0;
      if (i == 0 || i >= NREGS) w_data_d[i] = '0;

      if (w_rvk[i]) w_rdy_d[i] = 1'b1;
      if (w_rsv[i]) w_rdy_d[i] = 1'b0;
      if (i == 0 || i >= NCAPS) w_rdy_d[i] = 1'b1;
    end
  end

  // Sweep FSM next-state: index starts at 1 since x0 never holds a capability.
  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    unique case (r_state)
      StIdle: begin
        if (sweep_req_i) begin
          w_state_d = StSweep;
          w_idx_d   = 5'd1;
        end
      end
      StSweep: begin
        if (r_idx == 5'(NCAPS - 1)) w_state_d = StDone;
        else                        w_idx_d   = r_idx + 5'd1;
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // State registers; reset also aborts any sweep in progress.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data  <= '0;
      r_cap   <= '0;
      r_rdy   <= '1;
      r_alert <= 1'b0;
      r_state <= StIdle;
      r_idx   <= '0;
    end else begin
      r_data  <= w_data_d;
      r_cap   <= w_cap_d;
      r_rdy   <= w_rdy_d;
      r_alert <= w_conflict;
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
    end
  end

  // Read ports: stored value, optionally forwarded write, then revocation mask.
  always_comb begin
    for (int unsigned p = 0; p < NRdPorts; p++) begin
      logic [4:0] a;
      logic       fwd;
      a          = raddr_i[p];
      fwd        = WrFwd && w_wr_hit[a];
      rdata_o[p] = fwd ? w_wr_data[a] : r_data[a];
      rcap_o[p]  = fwd ? w_wr_cap[a] : r_cap[a];
      if ((TRVKBypass || fwd) && w_clr[a]) rcap_o[p][0] = 1'b0;
    end
  end

  assign reg_rdy_o    = r_rdy | (TRVKBypass ? w_rvk : 32'h0);
  assign sweep_busy_o = (r_state == StSweep);
  assign sweep_done_o = (r_state == StDone);
  assign alert_o      = r_alert;

endmodule

// File: tb/tb_cheri_regfile_mp.sv
// Scoreboard bench for cheri_regfile_mp: expectations are queued when
// stimulus is applied and popped when the corresponding output is sampled.
module tb_cheri_regfile_mp;
  localparam int unsigned CapW = 16;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic [2:0][4:0]       raddr_i;
  logic [2:0][31:0]      rdata_o;
  logic [2:0][CapW-1:0]  rcap_o;
  logic [1:0][4:0]       waddr_i;
  logic [1:0][31:0]      wdata_i;
  logic [1:0][CapW-1:0]  wcap_i;
  logic [1:0]            we_i;
  logic [1:0][4:0]       trvk_addr_i;
  logic [1:0]            trvk_en_i;
  logic [1:0]            trvk_clrtag_i;
  logic [4:0]            trsv_addr_i;
  logic                  trsv_en_i;
  logic [31:0]           reg_rdy_o;
  logic                  sweep_req_i;
  logic                  sweep_busy_o;
  logic                  sweep_done_o;
  logic                  alert_o;

  cheri_regfile_mp #(.CapW(CapW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .raddr_i(raddr_i), .rdata_o(rdata_o), .rcap_o(rcap_o),
    .waddr_i(waddr_i), .wdata_i(wdata_i), .wcap_i(wcap_i), .we_i(we_i),
    .trvk_addr_i(trvk_addr_i), .trvk_en_i(trvk_en_i), .trvk_clrtag_i(trvk_clrtag_i),
    .trsv_addr_i(trsv_addr_i), .trsv_en_i(trsv_en_i), .reg_rdy_o(reg_rdy_o),
    .sweep_req_i(sweep_req_i), .sweep_busy_o(sweep_busy_o),
    .sweep_done_o(sweep_done_o), .alert_o(alert_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       tag;
    logic [63:0] v;
  } sb_t;

  sb_t sb[$];
  int  n_total = 0;
  int  n_bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [63:0] v);
    sb_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input logic [63:0] obs);
    sb_t e;
    if (sb.size() == 0) begin
      check_val("sb_empty", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      check_val(e.tag, obs, e.v);
    end
  endtask

  task automatic idle();
    raddr_i = '0; waddr_i = '0; wdata_i = '0; wcap_i = '0; we_i = '0;
    trvk_addr_i = '0; trvk_en_i = '0; trvk_clrtag_i = '0;
    trsv_addr_i = '0; trsv_en_i = 1'b0; sweep_req_i = 1'b0;
  endtask

  task automatic step();
    @(negedge clk_i);
    idle();
  endtask

  // Read one register through port 2 in its own cycle.
  task automatic rd(input logic [4:0] a, output logic [31:0] d, output logic [CapW-1:0] c);
    step();
    raddr_i[2] = a;
    #1;
    d = rdata_o[2];
    c = rcap_o[2];
  endtask

  // Write every x1..x31 with a valid capability, two registers per cycle.
  task automatic fill();
    for (int i = 1; i < 32; i += 2) begin
      step();
      we_i[0] = 1'b1; waddr_i[0] = 5'(i);
      wdata_i[0] = 32'h1000_0000 | i; wcap_i[0] = CapW'((i << 4) | 1);
      if (i + 1 < 32) begin
        we_i[1] = 1'b1; waddr_i[1] = 5'(i + 1);
        wdata_i[1] = 32'h1000_0000 | (i + 1); wcap_i[1] = CapW'(((i + 1) << 4) | 1);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0]     d;
    logic [CapW-1:0] c;
    int              pulses;

    idle();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;

    // Reset state
    sb_push("rst_rdy", 64'hFFFF_FFFF);
    sb_push("rst_busy", 0); sb_push("rst_done", 0); sb_push("rst_alert", 0);
    #1;
    sb_pop(64'(reg_rdy_o)); sb_pop(64'(sweep_busy_o));
    sb_pop(64'(sweep_done_o)); sb_pop(64'(alert_o));
    sb_push("rst_x5_data", 0); sb_push("rst_x5_cap", 0);
    rd(5'd5, d, c);
    sb_pop(64'(d)); sb_pop(64'(c));

    // Dual-port collision on x5: port1 wins, alert for one cycle
    step();
    we_i = 2'b11; waddr_i[0] = 5'd5; waddr_i[1] = 5'd5;
    wdata_i[0] = 32'h11; wdata_i[1] = 32'h22;
    wcap_i[0] = 16'h0051; wcap_i[1] = 16'h0053;
    sb_push("coll_alert_pre", 0);
    #1; sb_pop(64'(alert_o));
    sb_push("coll_data", 32'h22); sb_push("coll_cap", 16'h0053); sb_push("coll_alert", 1);
    step(); raddr_i[0] = 5'd5; #1;
    sb_pop(64'(rdata_o[0])); sb_pop(64'(rcap_o[0])); sb_pop(64'(alert_o));
    sb_push("coll_alert_off", 0);
    step(); #1; sb_pop(64'(alert_o));

    // Write forwarding on x7, x8 unaffected
    step();
    we_i[0] = 1'b1; waddr_i[0] = 5'd7; wdata_i[0] = 32'hDEAD; wcap_i[0] = 16'h0071;
    raddr_i[0] = 5'd7; raddr_i[1] = 5'd8;
    sb_push("fwd_data", 32'hDEAD); sb_push("fwd_cap", 16'h0071); sb_push("fwd_other", 0);
    #1;
    sb_pop(64'(rdata_o[0])); sb_pop(64'(rcap_o[0])); sb_pop(64'(rdata_o[1]));

    // x0 is never written and never forwarded
    step();
    we_i[0] = 1'b1; waddr_i[0] = 5'd0; wdata_i[0] = 32'h55; wcap_i[0] = 16'h0001;
    sb_push("x0_fwd", 0);
    #1; sb_pop(64'(rdata_o[0]));
    sb_push("x0_data", 0); sb_push("x0_cap", 0);
    rd(5'd0, d, c); sb_pop(64'(d)); sb_pop(64'(c));

    // Reservation then bypassed revocation on x9
    step();
    we_i[0] = 1'b1; waddr_i[0] = 5'd9; wdata_i[0] = 32'h9; wcap_i[0] = 16'h0091;
    step(); trsv_en_i = 1'b1; trsv_addr_i = 5'd9;
    sb_push("rsv_rdy9", 0);
    step(); #1; sb_pop(64'(reg_rdy_o[9]));
    step();
    trvk_en_i[0] = 1'b1; trvk_clrtag_i[0] = 1'b1; trvk_addr_i[0] = 5'd9; raddr_i[0] = 5'd9;
    sb_push("rvk_rdy9_byp", 1); sb_push("rvk_cap_byp", 16'h0090);
    #1; sb_pop(64'(reg_rdy_o[9])); sb_pop(64'(rcap_o[0]));
    sb_push("rvk_cap_stored", 16'h0090); sb_push("rvk_rdy9_stored", 1);
    step(); raddr_i[0] = 5'd9; #1;
    sb_pop(64'(rcap_o[0])); sb_pop(64'(reg_rdy_o[9]));

    // Simultaneous reserve and revoke on x4: reserve wins
    step();
    trsv_en_i = 1'b1; trsv_addr_i = 5'd4; trvk_en_i[1] = 1'b1; trvk_addr_i[1] = 5'd4;
    sb_push("rsv_rvk_rdy4", 0);
    step(); #1; sb_pop(64'(reg_rdy_o[4]));

    // Revocation and write to x12 in one cycle: write lands, tag cleared
    step();
    we_i[1] = 1'b1; waddr_i[1] = 5'd12; wdata_i[1] = 32'h1234; wcap_i[1] = 16'h00C1;
    trvk_en_i[0] = 1'b1; trvk_clrtag_i[0] = 1'b1; trvk_addr_i[0] = 5'd12;
    sb_push("wr_rvk_data", 32'h1234); sb_push("wr_rvk_cap", 16'h00C0);
    rd(5'd12, d, c); sb_pop(64'(d)); sb_pop(64'(c));

    // Full sweep with a second (ignored) request at T+5
    fill();
    step(); sweep_req_i = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      sb_push($sformatf("swp_busy_%0d", k), 64'(k >= 1 && k <= 31));
      sb_push($sformatf("swp_done_%0d", k), 64'(k == 32));
    end
    for (int k = 1; k <= 36; k++) begin
      step();
      sweep_req_i = (k == 5);
      raddr_i[0] = 5'(k - 1);
      raddr_i[1] = 5'(k);
      #1;
      sb_pop(64'(sweep_busy_o)); sb_pop(64'(sweep_done_o));
      if (k >= 2 && k <= 32) check_val($sformatf("swp_cleared_%0d", k - 1), 64'(rcap_o[0][0]), 0);
      if (k <= 31) check_val($sformatf("swp_pending_%0d", k), 64'(rcap_o[1][0]), 1);
    end
    for (int i = 1; i < 32; i++) begin
      sb_push($sformatf("post_swp_data_%0d", i), 32'h1000_0000 | i);
      sb_push($sformatf("post_swp_cap_%0d", i), CapW'(i << 4));
      rd(5'(i), d, c); sb_pop(64'(d)); sb_pop(64'(c));
    end

    // Sweep with writes behind and exactly at the sweep index
    fill();
    step(); sweep_req_i = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      step();
      if (k == 10) begin
        we_i[0] = 1'b1; waddr_i[0] = 5'd3; wdata_i[0] = 32'h333; wcap_i[0] = 16'h0031;
      end
      if (k == 20) begin
        we_i[1] = 1'b1; waddr_i[1] = 5'd20; wdata_i[1] = 32'h2020; wcap_i[1] = 16'h0141;
      end
      sb_push($sformatf("swp2_done_%0d", k), 64'(k == 32));
      #1; sb_pop(64'(sweep_done_o));
    end
    sb_push("swp2_x3_cap", 16'h0031); sb_push("swp2_x3_data", 32'h333);
    rd(5'd3, d, c); sb_pop(64'(c)); sb_pop(64'(d));
    sb_push("swp2_x20_cap", 16'h0141);
    rd(5'd20, d, c); sb_pop(64'(c));
    sb_push("swp2_x4_cap", 16'h0040);
    rd(5'd4, d, c); sb_pop(64'(c));
    sb_push("swp2_x21_cap", 16'h0150);
    rd(5'd21, d, c); sb_pop(64'(c));

    // Reset at T+15 aborts the sweep
    fill();
    step(); sweep_req_i = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k == 15) rst_ni = 1'b0;
      sb_push($sformatf("swp3_busy_%0d", k), 64'(k < 15));
      #1; sb_pop(64'(sweep_busy_o));
    end
    check_val("swp3_done_rst", 64'(sweep_done_o), 0);
    for (int i = 1; i < 32; i++) begin
      sb_push($sformatf("swp3_cap_%0d", i), 0);
      rd(5'(i), d, c); sb_pop(64'(c));
    end
    step(); rst_ni = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      step(); #1;
      if (sweep_done_o || sweep_busy_o) pulses++;
    end
    check_val("swp3_no_done", 64'(pulses), 0);
    check_val("sb_drained", 64'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/cheri_regfile_mp.md
# cheri_regfile_mp

Multi-ported, parametrised successor of the CHERIoT capability register file. It holds NREGS 32-bit data words and NCAPS capability metadata entries (reg_cap_t), served through NRdPorts read ports and NWrPorts write ports. Tag reservation and revocation are handled on NTrvk revocation channels. A sequential tag-sweep engine invalidates every stored capability on request. The block sits in the ID/WB stage of the multi-issue core in place of the single-issue register file.

## Interface
- NREGS, 32: number of data registers; x0 is hard-wired to zero.
- NCAPS, 32: number of registers carrying capability metadata; NCAPS ≤ NREGS.
- NRdPorts, 3: number of read ports.
- NWrPorts, 2: number of write ports.
- NTrvk, 2: number of revocation channels.
- WrFwd, 1: forward same-cycle write data to the read ports.
- TRVKBypass, 1: make same-cycle revocation visible on reg_rdy_o and rcap_o.
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- raddr_i  input  NRdPorts×5  read addresses.
- rdata_o  output  NRdPorts×32  read data.
- rcap_o  output  NRdPorts×reg_cap_t  read capability metadata.
- waddr_i  input  NWrPorts×5  write addresses.
- wdata_i  input  NWrPorts×32  write data.
- wcap_i  input  NWrPorts×reg_cap_t  write metadata.
- we_i  input  NWrPorts  write enables; data and cap are always written together.
- trvk_addr_i  input  NTrvk×5  revocation target register.
- trvk_en_i  input  NTrvk  revocation valid; releases the reservation.
- trvk_clrtag_i  input  NTrvk  clear the valid bit of the target.
- trsv_addr_i  input  5  reservation target register.
- trsv_en_i  input  1  reserve the target (marks it not-ready).
- reg_rdy_o  output  32  per-register ready bit.
- sweep_req_i  input  1  start a tag sweep.
- sweep_busy_o  output  1  sweep in progress.
- sweep_done_o  output  1  one-cycle pulse when the sweep completes.
- alert_o  output  1  registered write-port conflict flag.

## Operation
- Reset values:
  - all data registers are 0 and all caps are NULL_REG_CAP;
  - reg_rdy_o = all ones;
  - sweep_busy_o = 0, sweep_done_o = 0, alert_o = 0;
  - the sweep FSM is in IDLE.
- Register 0 is never written. Reads of x0 return 0 and NULL_REG_CAP. Reads of addresses ≥ NCAPS return NULL_REG_CAP metadata.
- Write collision: when several enabled ports target the same register, the highest-index port wins. The conflict is flagged on alert_o in the next cycle, for one cycle.
- Priority when updating the cap of register i, highest first:
  1. revocation clear (any channel with en & clrtag matching i);
  2. write;
  3. sweep clear.
  - A revocation clears only the valid bit. A write performed in the same cycle still updates the data word and the other cap fields.
- Readiness:
  - reg_rdy bit i goes to 0 on trsv_en_i to i;
  - it goes to 1 on any trvk_en_i to i;
  - trsv wins when both target i in the same cycle;
  - bits 0 and bits ≥ NCAPS are always 1.
- TRVKBypass=1:
  - reg_rdy_o additionally ORs in the same-cycle trvk_en_i decode;
  - rcap_o valid is forced to 0 when a same-cycle trvk en & clrtag matches that port's raddr.
- WrFwd=1: a read of a register being written this cycle returns the winning port's wdata/wcap, with the same-cycle revocation mask applied. WrFwd=0: reads return the stored value.
- Sweep FSM:
  - IDLE → SWEEP on sweep_req_i, with the index set to 1.
  - In SWEEP, each cycle clears valid of cap[index] (subject to the priority above) and increments the index.
  - After index NCAPS-1 the FSM goes to DONE. DONE pulses sweep_done_o, then returns to IDLE.
  - sweep_req_i is ignored outside IDLE.
  - sweep_busy_o = 1 in SWEEP only.
  - The sweep does not alter data words or reg_rdy.
- Reset during a sweep aborts it: the FSM returns to IDLE, no done pulse is issued, and all caps are set to NULL.

## Timing
- Reads are combinational from stored state plus bypass/forward paths. Writes, revocations and reservations become visible in stored state one cycle later.
- Sweep: sweep_req_i in cycle T.
  - sweep_busy_o is high in cycles T+1 … T+NCAPS-1.
  - cap[k] has valid=0 from cycle T+k+1.
  - sweep_done_o is high in cycle T+NCAPS, and the FSM is in IDLE at T+NCAPS+1.
  - For NCAPS=32 the sweep is busy for 31 cycles.
- An index that is written during SWEEP after it has been swept keeps the written valid bit.
- A write arriving in the same cycle the sweep reaches that index wins, and the written valid bit is kept.

## Test plan
- Dual-port write collision:
  - stimulus: port0 writes x5=0x11, port1 writes x5=0x22;
  - response: next cycle x5 reads 0x22 and alert_o=1 for exactly one cycle.
- Write forwarding (WrFwd=1):
  - stimulus: write x7=0xDEAD with raddr_i[0]=7 in the same cycle;
  - response: rdata_o[0]=0xDEAD in that cycle.
- Reservation and revocation on x9:
  - stimulus: trsv to x9;
  - response: reg_rdy_o[9]=0 next cycle;
  - stimulus: trvk en & clrtag on x9 with TRVKBypass=1;
  - response: reg_rdy_o[9]=1 and rcap valid=0 in the same cycle; stored valid=0 next cycle.
- Simultaneous trsv and trvk on x4:
  - response: reg_rdy_o[4]=0 after the edge.
- Sweep with NCAPS=32, all caps valid, sweep_req_i at T:
  - response: busy for 31 cycles, done pulse at T+32, all caps invalid, data words unchanged;
  - a second sweep_req_i at T+5 is ignored.
- Sweep interrupted by a write, then by reset:
  - stimulus: write x3 with valid=1 at T+10;
  - response: x3 stays valid after done;
  - stimulus: rst_ni low at T+15;
  - response: busy=0, no done pulse, all caps NULL.
